// File: rtl/logic_acc_fold_pkg.sv
// Purpose: shared FSM state type and lane transform for the accumulate-and-fold datapath.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
package logic_acc_pkg;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_FOLD = 2'd1,
        ST_OUT  = 2'd2
    } t_acc_state;

    // Widest lane the helper handles; the lane module narrows the result to its own width.
    localparam int XF_MAX_BITS = 64;

    // f(x) = x ^ (x << 1). Truncating the result to the lane width is exact, because
    // result bit i depends only on x bits i and i-1.
    function automatic logic [XF_MAX_BITS-1:0] lane_xf(input logic [XF_MAX_BITS-1:0] x);
        return x ^ (x << 1);
    endfunction

endpackage

// File: rtl/logic_acc_fold_if.sv
// Purpose: beat-in / result-out handshake bundle for logic_acc_fold (clear, mode, data, count).
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the beat side, out_valid/out_ready on the result side.
interface logic_acc_fold_if #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_BURST_LEN = 4
);
    localparam int CNT_BITS = $clog2(PAR_BURST_LEN + 1);

    logic                     ib_clr;        // synchronous clear / abort burst
    logic                     ib_mode_sat;   // 1 = saturate, 0 = wrap; sampled on first beat
    logic [PAR_DATA_BITS-1:0] ivG_data;      // input beat
    logic                     ib_in_valid;
    logic                     ob_in_ready;
    logic [PAR_DATA_BITS-1:0] ovG_data;      // folded burst result
    logic                     ob_out_valid;
    logic                     ib_out_ready;
    logic                     ob_ovf;        // overflow seen in this result's burst
    logic [CNT_BITS-1:0]      ovG_count;     // beats accepted in the current burst

    // Source/consumer side.
    modport master (
        output ib_clr, ib_mode_sat, ivG_data, ib_in_valid, ib_out_ready,
        input  ob_in_ready, ovG_data, ob_out_valid, ob_ovf, ovG_count
    );

    // Accumulator side.
    modport slave (
        input  ib_clr, ib_mode_sat, ivG_data, ib_in_valid, ib_out_ready,
        output ob_in_ready, ovG_data, ob_out_valid, ob_ovf, ovG_count
    );

endinterface

// File: rtl/logic_acc_fold_lane.sv
// Purpose: one fold lane, lane_out = (lane_in ^ (lane_in << 1)) truncated to the lane width.
// Latency: combinational.
// Backpressure: none.
module logic_fold_lane
    import logic_acc_pkg::*;
#(
    parameter int PAR_LANE_BITS = 4
)(
    input  logic [PAR_LANE_BITS-1:0] lane_in,
    output logic [PAR_LANE_BITS-1:0] lane_out
);

    assign lane_out = PAR_LANE_BITS'(lane_xf(XF_MAX_BITS'(lane_in)));

endmodule

// File: rtl/logic_acc_fold.sv
// Purpose: sums a burst of PAR_BURST_LEN beats (wrap or saturate), then XORs a lane-reversed, lane-transformed copy onto the sum.
// Latency: last beat accepted in cycle N -> ob_out_valid in cycle N+2; min burst period PAR_BURST_LEN+2.
// Backpressure: ob_in_ready drops from the fold cycle until the result handshakes; the result holds while ib_out_ready=0.
// Ports: ib_clk/ib_rst (async active-high) plain; everything else through logic_acc_fold_if.slave.
module logic_acc_fold
    import logic_acc_pkg::*;
#(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_LANES     = 2,
    parameter int PAR_BURST_LEN = 4
)(
    input  logic            ib_clk,
    input  logic            ib_rst,
    logic_acc_fold_if.slave bus
);

    localparam int W        = PAR_DATA_BITS / PAR_LANES;
    localparam int CNT_BITS = $clog2(PAR_BURST_LEN + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(PAR_BURST_LEN - 1);

    t_acc_state               state;
    logic [PAR_DATA_BITS-1:0] sum;
    logic [CNT_BITS-1:0]      count;
    logic                     ovf;       // sticky across the burst
    logic                     mode_sat;  // latched on the first beat of the burst
    logic [PAR_DATA_BITS-1:0] fold;
    logic [PAR_DATA_BITS-1:0] result;
    logic [PAR_DATA_BITS:0]   add_ext;   // one extra bit for the carry out
    logic                     beat;

    // Output lane k takes the transform of sum lane PAR_LANES-1-k (lane order reversed).
    for (genvar k = 0; k < PAR_LANES; k++) begin : g_lane
        logic_fold_lane #(.PAR_LANE_BITS(W)) u_lane (
            .lane_in  (sum[(PAR_LANES-1-k)*W +: W]),
            .lane_out (fold[k*W +: W])
        );
    end

    assign result  = sum ^ fold;
    assign add_ext = {1'b0, sum} + {1'b0, bus.ivG_data};
    assign beat    = bus.ib_in_valid && (state == ST_ACC);

    assign bus.ob_in_ready = (state == ST_ACC);
    assign bus.ovG_count   = count;

    always_ff @(posedge ib_clk or posedge ib_rst) begin
        if (ib_rst) begin
            state            <= ST_ACC;
            sum              <= '0;
            count            <= '0;
            ovf              <= 1'b0;
            mode_sat         <= 1'b0;
            bus.ovG_data     <= '0;
            bus.ob_out_valid <= 1'b0;
            bus.ob_ovf       <= 1'b0;
        end else if (bus.ib_clr) begin
            // Clear wins over any beat or pending result in the same cycle.
            state            <= ST_ACC;
            sum              <= '0;
            count            <= '0;
            ovf              <= 1'b0;
            bus.ob_out_valid <= 1'b0;
            bus.ob_ovf       <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (beat) begin
                        if (count == '0) begin
                            // First beat starts a fresh sum, so it can never carry.
                            sum      <= bus.ivG_data;
                            mode_sat <= bus.ib_mode_sat;
                            ovf      <= 1'b0;
                        end else if (add_ext[PAR_DATA_BITS]) begin
                            sum <= mode_sat ? '1 : add_ext[PAR_DATA_BITS-1:0];
                            ovf <= 1'b1;
                        end else begin
                            sum <= add_ext[PAR_DATA_BITS-1:0];
                        end

                        if (count == LAST_CNT) begin
                            count <= '0;
                            state <= ST_FOLD;
                        end else begin
                            count <= count + CNT_BITS'(1);
                        end
                    end
                end

                ST_FOLD: begin
                    bus.ovG_data     <= result;
                    bus.ob_ovf       <= ovf;
                    bus.ob_out_valid <= 1'b1;
                    state            <= ST_OUT;
                end

                ST_OUT: begin
                    if (bus.ib_out_ready) begin
                        bus.ob_out_valid <= 1'b0;
                        sum              <= '0;
                        count            <= '0;
                        ovf              <= 1'b0;
                        state            <= ST_ACC;
                    end
                end

                default: state <= ST_ACC;
            endcase
        end
    end

endmodule
